leg_cpu: RTL and testbench

// - Top-level LEG core: 16-bit single-cycle RISC with internal program ROM, data RAM and memory-mapped 8N1 UART.
// - Sits at chip top; only external I/O is UART rx/tx plus two sticky error flags.
// - Runs the program loaded into ROM from reset; halts on HALT or on any error.

---
 rtl/leg_cpu.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_leg_cpu.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/leg_cpu.sv
// leg_cpu: 16-bit single-cycle LEG core with program ROM, data RAM and a
// memory-mapped 8N1 UART (TX at 0xFF00, status at 0xFF01, RX data at 0xFF02).
// Optional RX path: define UART_RX_EN to build the receiver. Without it rx is
// ignored, rx_valid stays 0 and UART_RX reads 0.
//
// TX FSM states
//   state    | meaning
//   TX_IDLE  | line high, ready to accept a byte
//   TX_START | driving the start bit (0)
//   TX_DATA  | shifting 8 data bits, LSB first
//   TX_STOP  | driving the stop bit (1); busy until it completes
// RX FSM states (UART_RX_EN only)
//   state    | meaning
//   RX_IDLE  | waiting for a low level on the synchronised line
//   RX_START | counting to mid start bit, then re-checking it is still low
//   RX_DATA  | sampling 8 data bits at bit centres
//   RX_STOP  | sampling the stop bit; byte kept only if it reads 1
//   RX_WAIT  | framing error seen, waiting for the line to return high
`timescale 1ns/1ps
module leg_cpu #(
    parameter string PROG_FILE    = "prog.hex",
    parameter int    PROG_WORDS   = 256,
    parameter int    DATA_WORDS   = 256,
    parameter int    CLKS_PER_BIT = 868
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic rx,
    output logic tx,
    output logic o_invalid_inst,
    output logic o_invalid_addr
);
    localparam int          PAW      = $clog2(PROG_WORDS);
    localparam int          DAW      = $clog2(DATA_WORDS);
    localparam logic [15:0] PROG_LIM = 16'(PROG_WORDS);
    localparam logic [15:0] DATA_LIM = 16'(DATA_WORDS);
    localparam logic [15:0] BIT_LEN  = 16'(CLKS_PER_BIT - 1);

    logic [15:0] rom  [PROG_WORDS];
    logic [15:0] ram  [DATA_WORDS];
    logic [15:0] regs [8];

    logic [15:0] pc, pc_inc, pc_next, inst, rd_v, rs_v, rt_v, simm6, simm9, ea;
    logic [15:0] ld_data, wr_data;
    logic [3:0]  op;
    logic [2:0]  rd, rs, rt;
    logic        halted, pc_ok, ld_ok, reg_we, ram_we, tx_start, rx_clear;
    logic        set_inst, set_addr, do_halt, tx_busy, rx_valid;
    logic [7:0]  rx_byte;

    assign pc_ok  = pc < PROG_LIM;
    assign inst   = pc_ok ? rom[pc[PAW-1:0]] : 16'h0000;
    assign op     = inst[15:12];
    assign rd     = inst[11:9];
    assign rs     = inst[8:6];
    assign rt     = inst[5:3];
    assign simm6  = {{10{inst[5]}}, inst[5:0]};
    assign simm9  = {{7{inst[8]}}, inst[8:0]};
    assign rd_v   = regs[rd];
    assign rs_v   = regs[rs];
    assign rt_v   = regs[rt];
    assign ea     = rs_v + simm6;
    assign pc_inc = pc + 16'd1;

    // Load data mux over the address map; ld_ok low means out-of-map.
    always_comb begin
        ld_data = 16'h0000;
        ld_ok   = 1'b1;
        if (ea < DATA_LIM)        ld_data = ram[ea[DAW-1:0]];
        else if (ea == 16'hFF00)  ld_data = 16'h0000;
        else if (ea == 16'hFF01)  ld_data = {14'h0000, rx_valid, tx_busy};
        else if (ea == 16'hFF02)  ld_data = {8'h00, rx_byte};
        else                      ld_ok   = 1'b0;
    end

    // Instruction decode / execute: next PC, writeback and side effects.
    always_comb begin
        reg_we   = 1'b0;
        wr_data  = 16'h0000;
        ram_we   = 1'b0;
        tx_start = 1'b0;
        rx_clear = 1'b0;
        set_inst = 1'b0;
        set_addr = 1'b0;
        do_halt  = 1'b0;
        pc_next  = pc_inc;
        if (halted) begin
            pc_next = pc;
        end else if (!pc_ok) begin
            set_addr = 1'b1;
            pc_next  = pc;
        end else begin
            case (op)
                4'h0: begin reg_we = 1'b1; wr_data = rs_v + rt_v; end
                4'h1: begin reg_we = 1'b1; wr_data = rs_v - rt_v; end
                4'h2: begin reg_we = 1'b1; wr_data = rs_v & rt_v; end
                4'h3: begin reg_we = 1'b1; wr_data = rs_v | rt_v; end
                4'h4: begin reg_we = 1'b1; wr_data = rs_v ^ rt_v; end
                4'h5: begin reg_we = 1'b1; wr_data = ea; end
                4'h6: begin reg_we = 1'b1; wr_data = simm9; end
                4'h7: begin
                    if (ld_ok) begin
                        reg_we   = 1'b1;
                        wr_data  = ld_data;
                        rx_clear = (ea == 16'hFF02);
                    end else begin
                        set_addr = 1'b1;
                        pc_next  = pc;
                    end
                end
                4'h8: begin
                    if (ea < DATA_LIM) begin
                        ram_we = 1'b1;
                    end else if (ea == 16'hFF00) begin
                        // Hold the PC until the transmitter can take the byte.
                        if (tx_busy) pc_next = pc;
                        else         tx_start = 1'b1;
                    end else begin
                        set_addr = 1'b1;
                        pc_next  = pc;
                    end
                end
                4'h9: if (rd_v == rs_v) pc_next = pc_inc + simm6;
                4'hA: if (rd_v != rs_v) pc_next = pc_inc + simm6;
                4'hB: begin reg_we = 1'b1; wr_data = pc_inc; pc_next = pc_inc + simm9; end
                4'hC: pc_next = rs_v;
                4'hF: begin do_halt = 1'b1; pc_next = pc; end
                default: begin set_inst = 1'b1; pc_next = pc; end
            endcase
        end
    end

    // Architectural state: PC, register file, halt and sticky error flags.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            pc             <= 16'h0000;
            regs           <= '{default: '0};
            halted         <= 1'b0;
            o_invalid_inst <= 1'b0;
            o_invalid_addr <= 1'b0;
        end else begin
            pc             <= pc_next;
            if (reg_we && rd != 3'd0) regs[rd] <= wr_data;
            halted         <= halted | set_inst | set_addr | do_halt;
            o_invalid_inst <= o_invalid_inst | set_inst;
            o_invalid_addr <= o_invalid_addr | set_addr;
        end
    end

    // Data RAM keeps its contents across reset.
    always_ff @(posedge i_clk) begin
        if (ram_we) ram[ea[DAW-1:0]] <= rd_v;
    end

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    tx_state_t   tx_state, tx_state_nx;
    logic [15:0] tx_cnt, tx_cnt_nx;
    logic [2:0]  tx_idx, tx_idx_nx;
    logic [7:0]  tx_sh, tx_sh_nx;

    // TX state register; async reset returns the line high at once.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= 16'h0000;
            tx_idx   <= 3'd0;
            tx_sh    <= 8'h00;
        end else begin
            tx_state <= tx_state_nx;
            tx_cnt   <= tx_cnt_nx;
            tx_idx   <= tx_idx_nx;
            tx_sh    <= tx_sh_nx;
        end
    end

    // TX next state: each bit lasts until the down-counter reaches zero.
    always_comb begin
        tx_state_nx = tx_state;
        tx_cnt_nx   = tx_cnt;
        tx_idx_nx   = tx_idx;
        tx_sh_nx    = tx_sh;
        if (tx_state != TX_IDLE && tx_cnt != 16'h0000) begin
            tx_cnt_nx = tx_cnt - 16'd1;
        end else begin
            case (tx_state)
                TX_IDLE: if (tx_start) begin
                    tx_state_nx = TX_START;
                    tx_cnt_nx   = BIT_LEN;
                    tx_sh_nx    = rd_v[7:0];
                end
                TX_START: begin
                    tx_state_nx = TX_DATA;
                    tx_cnt_nx   = BIT_LEN;
                    tx_idx_nx   = 3'd0;
                end
                TX_DATA: begin
                    tx_cnt_nx = BIT_LEN;
                    tx_sh_nx  = {1'b0, tx_sh[7:1]};
                    tx_idx_nx = tx_idx + 3'd1;
                    if (tx_idx == 3'd7) tx_state_nx = TX_STOP;
                end
                TX_STOP: tx_state_nx = TX_IDLE;
                default: tx_state_nx = TX_IDLE;
            endcase
        end
    end

    assign tx_busy = (tx_state != TX_IDLE);
    assign tx      = (tx_state == TX_START) ? 1'b0 :
                     (tx_state == TX_DATA)  ? tx_sh[0] : 1'b1;

`ifdef UART_RX_EN
    localparam logic [15:0] HALF_LEN = 16'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
    rx_state_t   rx_state, rx_state_nx;
    logic [1:0]  rx_sync;
    logic        rx_s, rx_done;
    logic [15:0] rx_cnt, rx_cnt_nx;
    logic [2:0]  rx_idx, rx_idx_nx;
    logic [7:0]  rx_sh, rx_sh_nx;

    assign rx_s = rx_sync[1];

    // RX synchroniser, state register and received-byte holding register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rx_sync  <= 2'b11;
            rx_state <= RX_IDLE;
            rx_cnt   <= 16'h0000;
            rx_idx   <= 3'd0;
            rx_sh    <= 8'h00;
            rx_byte  <= 8'h00;
            rx_valid <= 1'b0;
        end else begin
            rx_sync  <= {rx_sync[0], rx};
            rx_state <= rx_state_nx;
            rx_cnt   <= rx_cnt_nx;
            rx_idx   <= rx_idx_nx;
            rx_sh    <= rx_sh_nx;
            if (rx_done) begin
                rx_byte  <= rx_sh;
                rx_valid <= 1'b1;
            end else if (rx_clear) begin
                rx_valid <= 1'b0;
            end
        end
    end

    // RX next state: half-bit delay to the start centre, then full bits.
    always_comb begin
        rx_state_nx = rx_state;
        rx_cnt_nx   = rx_cnt;
        rx_idx_nx   = rx_idx;
        rx_sh_nx    = rx_sh;
        rx_done     = 1'b0;
        if (rx_state inside {RX_START, RX_DATA, RX_STOP} && rx_cnt != 16'h0000) begin
            rx_cnt_nx = rx_cnt - 16'd1;
        end else begin
            case (rx_state)
                RX_IDLE: if (!rx_s) begin
                    rx_state_nx = RX_START;
                    rx_cnt_nx   = HALF_LEN;
                end
                RX_START: begin
                    if (!rx_s) begin
                        rx_state_nx = RX_DATA;
                        rx_cnt_nx   = BIT_LEN;
                        rx_idx_nx   = 3'd0;
                    end else begin
                        rx_state_nx = RX_IDLE;
                    end
                end
                RX_DATA: begin
                    rx_sh_nx  = {rx_s, rx_sh[7:1]};
                    rx_cnt_nx = BIT_LEN;
                    rx_idx_nx = rx_idx + 3'd1;
                    if (rx_idx == 3'd7) rx_state_nx = RX_STOP;
                end
                RX_STOP: begin
                    if (rx_s) begin
                        rx_done     = 1'b1;
                        rx_state_nx = RX_IDLE;
                    end else begin
                        rx_state_nx = RX_WAIT;
                    end
                end
                RX_WAIT: if (rx_s) rx_state_nx = RX_IDLE;
                default: rx_state_nx = RX_IDLE;
            endcase
        end
    end
`else
    logic unused_rx;
    assign unused_rx = rx | rx_clear;
    assign rx_valid  = 1'b0;
    assign rx_byte   = 8'h00;
`endif

endmodule

// File: tb/tb_leg_cpu.sv
// tb_leg_cpu: directed programs for leg_cpu with hand-computed results.
`timescale 1ns/1ps
module tb_leg_cpu;
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx = 1'b1;
    logic tx, inv_inst, inv_addr;

    int n_checks = 0;
    int n_errors = 0;
    int gap;
    logic [15:0] prog [$];

    leg_cpu #(
        .PROG_FILE   (""),
        .PROG_WORDS  (256),
        .DATA_WORDS  (256),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst_n),
        .rx            (rx),
        .tx            (tx),
        .o_invalid_inst(inv_inst),
        .o_invalid_addr(inv_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic boot();
        rst_n = 1'b0;
        step(2);
        for (int i = 0; i < 256; i++)
            dut.rom[i[7:0]] = (i < prog.size()) ? prog[i] : 16'h0000;
        step(1);
        rst_n = 1'b1;
    endtask

    task automatic wait_halt(input string tag, input int limit);
        int n;
        n = 0;
        while (!dut.halted && n < limit) begin
            step(1);
            n++;
        end
        chk(tag, 16'(dut.halted), 16'd1);
    endtask

    task automatic expect_frame(input string tag, input logic [9:0] frame, output int waited);
        int n;
        logic [9:0] f;
        n = 0;
        f = frame;
        while (tx !== 1'b0 && n < 40 * CPB) begin
            step(1);
            n++;
        end
        waited = n;
        chk({tag, " start found"}, 16'(n < 40 * CPB), 16'd1);
        step(CPB / 2);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("%s bit%0d", tag, i), 16'(tx), 16'(f[0]));
            f = f >> 1;
            if (i < 9) step(CPB);
        end
    endtask

    task automatic send_rx(input logic [9:0] frame);
        logic [9:0] f;
        f = frame;
        for (int i = 0; i < 10; i++) begin
            rx = f[0];
            f = f >> 1;
            step(CPB);
        end
        rx = 1'b1;
    endtask

    initial begin
        // Reset values
        step(2);
        chk("rst pc", dut.pc, 16'h0000);
        chk("rst tx", 16'(tx), 16'd1);
        chk("rst inv_inst", 16'(inv_inst), 16'd0);
        chk("rst inv_addr", 16'(inv_addr), 16'd0);

        // All-NOP ROM runs off the end at PC 256
        prog = {};
        boot();
        step(256);
        chk("nop pc256", dut.pc, 16'd256);
        chk("nop addr before", 16'(inv_addr), 16'd0);
        step(1);
        chk("nop addr set", 16'(inv_addr), 16'd1);
        step(20);
        chk("nop pc frozen", dut.pc, 16'd256);
        chk("nop inst clear", 16'(inv_inst), 16'd0);

        // ALU, store and load
        prog = {16'h6205, 16'h65FD, 16'h0650, 16'h8600, 16'h7800,
                16'h1A50, 16'h4C50, 16'h2E50, 16'hF000};
        boot();
        wait_halt("alu halt", 50);
        chk("alu r1", dut.regs[3'd1], 16'h0005);
        chk("alu r2", dut.regs[3'd2], 16'hFFFD);
        chk("alu r3 add", dut.regs[3'd3], 16'h0002);
        chk("alu r4 lw", dut.regs[3'd4], 16'h0002);
        chk("alu ram0", dut.ram[8'd0], 16'h0002);
        chk("alu r5 sub", dut.regs[3'd5], 16'h0008);
        chk("alu r6 xor", dut.regs[3'd6], 16'hFFF8);
        chk("alu r7 and", dut.regs[3'd7], 16'h0005);
        chk("alu pc", dut.pc, 16'd8);
        chk("alu flags", 16'({inv_inst, inv_addr}), 16'd0);

        // JAL, ADDI, BNE taken, JR
        prog = {16'h6203, 16'hBE02, 16'hF000, 16'hF000, 16'h547F,
                16'hA441, 16'hF000, 16'hC1C0};
        boot();
        wait_halt("br halt", 50);
        chk("br r7 link", dut.regs[3'd7], 16'h0002);
        chk("br r2 addi", dut.regs[3'd2], 16'h0002);
        chk("br pc", dut.pc, 16'd2);

        // Load just past RAM
        prog = {16'h62FF, 16'h7441, 16'hF000};
        boot();
        wait_halt("oob halt", 50);
        chk("oob addr flag", 16'(inv_addr), 16'd1);
        chk("oob inst flag", 16'(inv_inst), 16'd0);
        chk("oob pc", dut.pc, 16'd1);
        chk("oob r2 unwritten", dut.regs[3'd2], 16'h0000);

        // Invalid opcode at PC 3
        prog = {16'h0000, 16'h0000, 16'h0000, 16'hD000};
        boot();
        step(3);
        chk("inv pc3", dut.pc, 16'd3);
        chk("inv before", 16'(inv_inst), 16'd0);
        step(1);
        chk("inv set", 16'(inv_inst), 16'd1);
        step(5);
        chk("inv pc held", dut.pc, 16'd3);
        rst_n = 1'b0;
        #1;
        chk("inv cleared by rst", 16'(inv_inst), 16'd0);
        step(1);

        // Two UART bytes, the second stalls until the first frame ends
        prog = {16'h6300, 16'h6441, 16'h8440, 16'h665A, 16'h8640, 16'hF000};
        boot();
        step(2);
        chk("tx busy before", 16'(dut.tx_busy), 16'd0);
        step(1);
        chk("tx busy after accept", 16'(dut.tx_busy), 16'd1);
        expect_frame("tx 0x41", 10'h282, gap);
        chk("tx stall pc", dut.pc, 16'd4);
        chk("tx busy in stop", 16'(dut.tx_busy), 16'd1);
        expect_frame("tx 0x5A", 10'h2B4, gap);
        chk("tx back-to-back", 16'(gap <= CPB / 2 + 1), 16'd1);
        wait_halt("tx halt", 4 * CPB);
        chk("tx final pc", dut.pc, 16'd5);

        // Reset mid start bit forces the line high without a clock edge
        prog = {16'h6300, 16'h6441, 16'h8440, 16'hF000};
        boot();
        step(5);
        chk("midrst tx low", 16'(tx), 16'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst tx high", 16'(tx), 16'd1);
        step(1);

`ifdef UART_RX_EN
        // Poll status until rx_valid, then read data and status again
        prog = {16'h6300, 16'h6802, 16'h7441, 16'h26A0, 16'h963D,
                16'h7A42, 16'h7C41, 16'hF000};
        boot();
        step(4);
        send_rx(10'h2B4);
        wait_halt("rx halt", 4 * CPB);
        chk("rx status", dut.regs[3'd2], 16'h0002);
        chk("rx data", dut.regs[3'd5], 16'h005A);
        chk("rx status after read", dut.regs[3'd6], 16'h0000);

        // Line stuck low never delivers a byte
        prog = {16'hF000};
        boot();
        rx = 1'b0;
        step(12 * CPB);
        chk("rx low valid a", 16'(dut.rx_valid), 16'd0);
        step(12 * CPB);
        chk("rx low valid b", 16'(dut.rx_valid), 16'd0);
        rx = 1'b1;
        step(2);
`else
        // Receiver absent: status and data read as zero while rx toggles
        prog = {16'h6300, 16'h7441, 16'h7A42, 16'hF000};
        boot();
        send_rx(10'h2B4);
        wait_halt("norx halt", 20);
        chk("norx status", dut.regs[3'd2], 16'h0000);
        chk("norx data", dut.regs[3'd5], 16'h0000);
        chk("norx valid", 16'(dut.rx_valid), 16'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
